spi_master_param: RTL
=====================

# spi_master_param

Parametrised SPI master engine, next generation of the single-byte SPI controller: programmable transfer length up to DATA_W bits, all four CPOL/CPHA modes, MSB/LSB-first ordering, a runtime clock divider and NUM_CS active-low chip selects with automatic framing. It sits between the AXI register front end, which drives the command/config inputs and reads the status outputs, and the SPI pins. One transfer runs per start pulse. Completion raises a sticky IRQ flag.

## Interface
- DATA_W, 32, maximum transfer length in bits (8..32)
- NUM_CS, 4, number of chip-select outputs (1..8)
- DIV_W, 8, width of the clock-divider input
- clk  in  1  system clock
- RST  in  1  reset, asynchronous, active-high (one clock; reset is asynchronous and active-high)
- i_start  in  1  single-cycle transfer request
- i_tx_data  in  DATA_W  transmit word, right-justified
- i_len  in  $clog2(DATA_W+1)  bits to transfer
- i_cs_sel  in  $clog2(NUM_CS) (min 1)  chip-select index
- i_cpol, i_cpha, i_lsb_first  in  1 each  mode bits
- i_clk_div  in  DIV_W  SCLK half-period = i_clk_div+1 clk cycles
- i_irq_en  in  1  enable IRQ flag setting
- i_irq_clr  in  1  clear IRQ and collision flags
- o_busy  out  1  transfer in progress
- o_done  out  1  one-cycle completion pulse
- o_rx_data  out  DATA_W  received word, right-justified
- o_IRQ  out  1  sticky completion flag
- o_collision  out  1  sticky start-while-busy flag
- o_sclk, o_mosi  out  1 each  SPI clock and data
- o_cs_n  out  NUM_CS  active-low chip selects
- i_miso  in  1  SPI data in

## Operation
- States: IDLE, CS_SETUP, SHIFT, CS_HOLD.
- IDLE:
  - o_sclk = i_cpol (combinational); o_mosi = 0; o_cs_n all 1.
  - i_start latches tx, len, cs_sel, cpol, cpha, lsb_first and div, then enters CS_SETUP.
  - Inputs are ignored during a transfer except i_start and i_irq_clr.
- Length rule: the effective length L is i_len. If i_len is 0 or greater than DATA_W, L = DATA_W.
- Bit order:
  - MSB-first: transmits tx[L-1] down to tx[0]. The bit received at step k goes to rx[L-1-k].
  - LSB-first: transmits tx[0] up to tx[L-1]. The bit received at step k goes to rx[k].
- o_rx_data bits at index L and above read 0.
- CS_SETUP lasts one half-period:
  - o_cs_n[sel] = 0.
  - With CPHA=0, the first bit is on o_mosi from entry.
- SHIFT produces 2L SCLK edges, one per half-period. The first edge is the leading edge (away from CPOL).
  - CPHA=0: sample i_miso on leading edges; drive the next bit on trailing edges. No drive occurs after the last edge.
  - CPHA=1: drive the bit on leading edges; sample on trailing edges.
- CS_HOLD lasts one half-period:
  - SCLK = CPOL and o_mosi holds its value.
  - On exit: o_cs_n goes all 1, o_rx_data updates, o_done pulses, the IRQ flag is set if i_irq_en, and the FSM returns to IDLE.
- o_rx_data holds its value until the next completion.
- Collision: i_start while o_busy sets o_collision; the transfer continues unaffected.
- i_irq_clr clears o_IRQ and o_collision. If a set and a clear occur in the same cycle, the set wins.
- Asynchronous reset, including mid-transfer, takes effect immediately:
  - FSM goes to IDLE; o_cs_n all 1; o_busy, o_done, o_IRQ and o_collision go 0; o_rx_data goes 0; o_mosi goes 0.
  - o_sclk = i_cpol.
  - No o_done pulse is produced for the aborted transfer.

## Timing
- With i_start sampled at edge T, o_busy and o_cs_n[sel]=0 are both visible from T+1.
- A transfer of L bits with divider D keeps CS asserted for exactly (2L+2)(D+1) cycles.
- o_done is high in the first cycle with CS deasserted and o_busy=0. A new i_start is accepted in that same cycle.
- o_sclk, o_mosi and o_cs_n are driven from registers (no glitches) during a transfer.
- o_IRQ rises in the same cycle as o_done.

## Configuration
- SPI_MASTER_LOOPBACK_EN
  - Defined: adds input port i_loopback (1 bit, latched at start). When the latched bit is 1, the sample path takes the internal o_mosi value instead of i_miso.
  - Undefined: the port is absent and sampling always uses i_miso.

## Test plan
- Mode 0, MSB-first, L=8, D=1, tx=0xA5, slave returns 0x3C:
  - MOSI bits 1,0,1,0,0,1,0,1 appear on leading edges.
  - o_rx_data=0x0000003C.
  - CS low for 36 cycles; o_done one cycle.
- Mode 3, LSB-first, L=12, D=0, tx=0x0F0, slave echoes MOSI: o_rx_data=0x0F0 and o_sclk idles high.
- i_len=0 with tx=0xDEADBEEF, loopback macro on and i_loopback=1: 32 bits are shifted and o_rx_data=0xDEADBEEF.
- i_start pulsed mid-transfer, then i_irq_en=1:
  - o_collision=1 and the first transfer completes normally.
  - o_IRQ=1 after completion.
  - i_irq_clr pulsed on a later done cycle leaves o_IRQ=1 (set wins).
- RST asserted at bit 5 of a CPOL=1 transfer:
  - o_cs_n=all 1, o_sclk=1 and o_busy=0 immediately.
  - No o_done pulse; the next start runs cleanly.
- NUM_CS=4, back-to-back starts on the done cycle with cs_sel 2 then 3: only the selected o_cs_n bit asserts each time, with no idle gap cycle.

Source files
------------

// File: rtl/spi_master_param.sv
// SPI master: 1..DATA_W bit transfers, all CPOL/CPHA modes, MSB/LSB first, runtime divider, framed chip selects.
// Optional SPI_MASTER_LOOPBACK_EN adds i_loopback, which routes the internal MOSI into the sample path.
module spi_master_param #(
    parameter int DATA_W = 32,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8
) (
    input  logic                                          clk,
    input  logic                                          RST,
    input  logic                                          i_start,
    input  logic [DATA_W-1:0]                             i_tx_data,
    input  logic [$clog2(DATA_W+1)-1:0]                   i_len,
    input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] i_cs_sel,
    input  logic                                          i_cpol,
    input  logic                                          i_cpha,
    input  logic                                          i_lsb_first,
    input  logic [DIV_W-1:0]                              i_clk_div,
    input  logic                                          i_irq_en,
    input  logic                                          i_irq_clr,
    output logic                                          o_busy,
    output logic                                          o_done,
    output logic [DATA_W-1:0]                             o_rx_data,
    output logic                                          o_IRQ,
    output logic                                          o_collision,
    output logic                                          o_sclk,
    output logic                                          o_mosi,
    output logic [NUM_CS-1:0]                             o_cs_n,
    output logic [1:0]                                    o_dbg_state,
    input  logic                                          i_miso
`ifdef SPI_MASTER_LOOPBACK_EN
    ,
    input  logic                                          i_loopback
`endif
);
    localparam int LEN_W = $clog2(DATA_W + 1);
    localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        if (len == '0 || int'(len) > DATA_W) return LEN_W'(DATA_W);
        return len;
    endfunction

    // Step k maps to the same bit position for both transmit and receive.
    function automatic logic [IDX_W-1:0] bit_idx(input logic lsb, input logic [LEN_W-1:0] len,
                                                 input logic [LEN_W-1:0] k);
        logic [LEN_W-1:0] r;
        r = lsb ? k : (len - k - LEN_W'(1));
        return r[IDX_W-1:0];
    endfunction

    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] r;
        r = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (sel == CS_W'(i)) r[i] = 1'b0;
        end
        return r;
    endfunction

    logic [1:0]        state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d;
    logic [LEN_W:0]    edge_q, edge_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rx_out_q, rx_out_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d, mosi_q, mosi_d;
    logic              done_q, done_d, irq_q, irq_d, coll_q, coll_d;
    logic [LEN_W-1:0]  start_len, k;
    logic              half_end, lead, sample_bit, busy;

    assign start_len = eff_len(i_len);
    assign half_end  = (cnt_q == div_q);
    assign k         = edge_q[LEN_W:1];
    assign lead      = ~edge_q[0];
    assign busy      = (state_q != ST_IDLE);

`ifdef SPI_MASTER_LOOPBACK_EN
    logic lb_q, lb_d;
    assign sample_bit = lb_q ? mosi_q : i_miso;
`else
    assign sample_bit = i_miso;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        edge_d   = edge_q;
        len_d    = len_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        rx_out_d = rx_out_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        lsb_d    = lsb_q;
        cs_n_d   = cs_n_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        done_d   = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
        lb_d     = lb_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                    edge_d  = '0;
                    div_d   = i_clk_div;
                    len_d   = start_len;
                    tx_d    = i_tx_data;
                    rx_d    = '0;
                    cpol_d  = i_cpol;
                    cpha_d  = i_cpha;
                    lsb_d   = i_lsb_first;
                    cs_n_d  = cs_decode(i_cs_sel);
                    sclk_d  = i_cpol;
                    mosi_d  = i_cpha ? 1'b0 : i_tx_data[bit_idx(i_lsb_first, start_len, '0)];
`ifdef SPI_MASTER_LOOPBACK_EN
                    lb_d    = i_loopback;
`endif
                end
            end
            ST_SETUP, ST_SHIFT: begin
                cnt_d = cnt_q + DIV_W'(1);
                if (half_end) begin
                    cnt_d = '0;
                    if (state_q == ST_SHIFT && edge_q == {len_q, 1'b0}) begin
                        state_d = ST_HOLD;
                    end else begin
                        // The SETUP->SHIFT boundary is edge 0, the first leading edge.
                        state_d = ST_SHIFT;
                        edge_d  = edge_q + (LEN_W+1)'(1);
                        sclk_d  = ~sclk_q;
                        if (lead != cpha_q) rx_d[bit_idx(lsb_q, len_q, k)] = sample_bit;
                        if (lead && cpha_q) mosi_d = tx_q[bit_idx(lsb_q, len_q, k)];
                        if (!lead && !cpha_q && ((k + LEN_W'(1)) < len_q))
                            mosi_d = tx_q[bit_idx(lsb_q, len_q, k + LEN_W'(1))];
                    end
                end
            end
            default: begin
                cnt_d = cnt_q + DIV_W'(1);
                if (half_end) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    cs_n_d   = '1;
                    mosi_d   = 1'b0;
                    rx_out_d = rx_q;
                    done_d   = 1'b1;
                end
            end
        endcase
        // Completion keeps setting the flag through the done cycle, so a clear there loses.
        irq_d  = (i_irq_en && (done_d || done_q)) ? 1'b1 : (irq_q && !i_irq_clr);
        coll_d = (i_start && busy) || (coll_q && !i_irq_clr);
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            edge_q   <= '0;
            len_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            rx_out_q <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            cs_n_q   <= '1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            done_q   <= 1'b0;
            irq_q    <= 1'b0;
            coll_q   <= 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
            lb_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            edge_q   <= edge_d;
            len_q    <= len_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            rx_out_q <= rx_out_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            lsb_q    <= lsb_d;
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            done_q   <= done_d;
            irq_q    <= irq_d;
            coll_q   <= coll_d;
`ifdef SPI_MASTER_LOOPBACK_EN
            lb_q     <= lb_d;
`endif
        end
    end

    assign o_sclk      = (state_q == ST_IDLE) ? i_cpol : sclk_q;
    assign o_mosi      = mosi_q;
    assign o_cs_n      = cs_n_q;
    assign o_busy      = busy;
    assign o_done      = done_q;
    assign o_rx_data   = rx_out_q;
    assign o_IRQ       = irq_q;
    assign o_collision = coll_q;
    assign o_dbg_state = state_q;
endmodule
